// File: rtl/evt_dispatch_arb_pkg.sv
// Shared event-unit definitions for the dispatch arbiter.
package evt_dispatch_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } evt_disp_state_e;

endpackage

// File: rtl/evt_dispatch_arb_ff1.sv
// Find-first-one: index of the lowest set bit of vec, plus an any-set flag.
module ff1_loop #(
    parameter int W  = 8,
    parameter int IW = $clog2(W)
) (
    input  logic [W-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          found
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx   = '0;
        found = |vec;
        for (int i = W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IW'(i);
        end
    end

endmodule

// File: rtl/evt_dispatch_arb.sv
// Pending-event register with lowest-index dispatch offer, flush and
// saturating overflow counter.
module evt_dispatch_arb
    import evt_dispatch_arb_pkg::*;
#(
    parameter int NB_EVT = 8,
    parameter int CNT_W  = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NB_EVT-1:0]         evt_set_i,
    input  logic [NB_EVT-1:0]         evt_mask_i,
    input  logic                      flush_i,
    output logic                      valid_o,
    output logic [$clog2(NB_EVT)-1:0] id_o,
    input  logic                      ack_i,
    output logic [NB_EVT-1:0]         pending_o,
    output logic                      ovf_o,
    output logic [CNT_W-1:0]          ovf_cnt_o,
    input  logic                      ovf_clr_i
);

    localparam int IDX_W = $clog2(NB_EVT);

    evt_disp_state_e   state_q;
    logic [NB_EVT-1:0] pending_q;
    logic [IDX_W-1:0]  id_q;
    logic [CNT_W-1:0]  ovf_cnt_q;

    logic              xfer;
    logic [NB_EVT-1:0] ack_vec;
    logic [IDX_W-1:0]  sel_idx;
    logic              sel_found;

    ff1_loop #(.W(NB_EVT), .IW(IDX_W)) u_ff1 (
        .vec   (pending_q & evt_mask_i),
        .idx   (sel_idx),
        .found (sel_found)
    );

    assign xfer    = (state_q == OFFER) && ack_i;
    assign ack_vec = xfer ? (NB_EVT'(1) << id_q) : '0;

    // A set landing on the line being acked is a re-arm, not a collision.
    assign ovf_o = |(evt_set_i & pending_q & ~ack_vec);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        pending_q <= '0;
        else if (flush_i) pending_q <= '0;
        else              pending_q <= (pending_q & ~ack_vec) | evt_set_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!flush_i && sel_found) begin
                        state_q <= OFFER;
                        id_q    <= sel_idx;
                    end
                end
                OFFER: begin
                    if (flush_i || xfer) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                           ovf_cnt_q <= '0;
        else if (ovf_clr_i)                  ovf_cnt_q <= '0;
        else if (ovf_o && ovf_cnt_q != '1)   ovf_cnt_q <= ovf_cnt_q + 1'b1;
    end

    assign valid_o   = (state_q == OFFER);
    assign id_o      = id_q;
    assign pending_o = pending_q;
    assign ovf_cnt_o = ovf_cnt_q;

endmodule

// File: tb/tb_evt_dispatch_arb.sv
// Directed bench for evt_dispatch_arb (NB_EVT=8, CNT_W=2).
module tb_evt_dispatch_arb;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [7:0] evt_set_i = '0;
    logic [7:0] evt_mask_i = 8'hFF;
    logic       flush_i = 1'b0;
    logic       valid_o;
    logic [2:0] id_o;
    logic       ack_i = 1'b0;
    logic [7:0] pending_o;
    logic       ovf_o;
    logic [1:0] ovf_cnt_o;
    logic       ovf_clr_i = 1'b0;

    int errors = 0;
    int checks = 0;

    evt_dispatch_arb #(.NB_EVT(8), .CNT_W(2)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .evt_set_i  (evt_set_i),
        .evt_mask_i (evt_mask_i),
        .flush_i    (flush_i),
        .valid_o    (valid_o),
        .id_o       (id_o),
        .ack_i      (ack_i),
        .pending_o  (pending_o),
        .ovf_o      (ovf_o),
        .ovf_cnt_o  (ovf_cnt_o),
        .ovf_clr_i  (ovf_clr_i)
    );

    always #5 clk_i = ~clk_i;

    // Advance to just after the next rising edge; inputs are driven and
    // outputs sampled here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick(); tick();
        rst_i = 1'b0;
        tick();
        checks++; if (valid_o !== 1'b0)   begin errors++; $display("FAIL reset_valid got=%0h want=0", valid_o); end
        checks++; if (id_o !== 3'd0)      begin errors++; $display("FAIL reset_id got=%0h want=0", id_o); end
        checks++; if (pending_o !== 8'h0) begin errors++; $display("FAIL reset_pending got=%0h want=0", pending_o); end
        checks++; if (ovf_o !== 1'b0)     begin errors++; $display("FAIL reset_ovf got=%0h want=0", ovf_o); end
        checks++; if (ovf_cnt_o !== 2'd0) begin errors++; $display("FAIL reset_ovf_cnt got=%0h want=0", ovf_cnt_o); end
    endtask

    task automatic test_single();
        ack_i = 1'b1;
        evt_set_i = 8'h10;                       // cycle 0
        tick(); evt_set_i = '0;                  // cycle 1
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL single_c1_valid got=%0h want=0", valid_o); end
        checks++; if (pending_o !== 8'h10) begin errors++; $display("FAIL single_c1_pending got=%0h want=10", pending_o); end
        tick();                                  // cycle 2
        checks++; if (valid_o !== 1'b1)    begin errors++; $display("FAIL single_c2_valid got=%0h want=1", valid_o); end
        checks++; if (id_o !== 3'd4)       begin errors++; $display("FAIL single_c2_id got=%0h want=4", id_o); end
        tick();                                  // cycle 3
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL single_c3_pending got=%0h want=0", pending_o); end
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL single_c3_valid got=%0h want=0", valid_o); end
        ack_i = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        logic [3:0] exp_v [1:5];
        logic [2:0] exp_id [1:5];
        exp_v  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_id = '{3'd0, 3'd2, 3'd2, 3'd7, 3'd7};
        ack_i = 1'b1;
        evt_set_i = 8'h84;
        tick(); evt_set_i = '0;
        for (int c = 1; c <= 5; c++) begin
            if (c > 1) tick();
            checks++; if (valid_o !== exp_v[c][0]) begin errors++; $display("FAIL prio_valid c%0d got=%0h want=%0h", c, valid_o, exp_v[c][0]); end
            if (exp_v[c][0]) begin
                checks++; if (id_o !== exp_id[c]) begin errors++; $display("FAIL prio_id c%0d got=%0h want=%0h", c, id_o, exp_id[c]); end
            end
        end
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL prio_pending_end got=%0h want=0", pending_o); end
        ack_i = 1'b0;
        tick();
    endtask

    task automatic test_backpressure_mask();
        evt_set_i = 8'h08;
        tick(); evt_set_i = '0;
        tick();                                  // offer id 3
        evt_mask_i = 8'hF7;
        evt_set_i  = 8'h02;                      // lower index arrives mid-offer
        for (int c = 0; c < 5; c++) begin
            checks++; if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid c%0d got=%0h want=1", c, valid_o); end
            checks++; if (id_o !== 3'd3)    begin errors++; $display("FAIL bp_id c%0d got=%0h want=3", c, id_o); end
            tick(); evt_set_i = '0;
        end
        ack_i = 1'b1;
        tick(); ack_i = 1'b0;
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL bp_bubble_valid got=%0h want=0", valid_o); end
        checks++; if (pending_o !== 8'h02) begin errors++; $display("FAIL bp_pending got=%0h want=02", pending_o); end
        tick();
        checks++; if (valid_o !== 1'b1 || id_o !== 3'd1) begin errors++; $display("FAIL bp_next got=%0h/%0h want=1/1", valid_o, id_o); end
        ack_i = 1'b1;
        tick(); ack_i = 1'b0;
        evt_mask_i = 8'hFF;
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL bp_drain got=%0h want=0", pending_o); end
        tick();
    endtask

    task automatic test_overflow();
        evt_set_i = 8'h02;
        tick();
        evt_set_i = 8'h02;                       // second hit while pending
        #1;
        checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_pulse got=%0h want=1", ovf_o); end
        tick(); evt_set_i = '0; #1;
        checks++; if (ovf_o !== 1'b0)     begin errors++; $display("FAIL ovf_single got=%0h want=0", ovf_o); end
        checks++; if (ovf_cnt_o !== 2'd1) begin errors++; $display("FAIL ovf_cnt1 got=%0h want=1", ovf_cnt_o); end
        for (int n = 2; n <= 5; n++) begin
            evt_set_i = 8'h02;
            tick(); evt_set_i = '0;
            checks++; if (ovf_cnt_o !== ((n > 3) ? 2'd3 : 2'(n))) begin errors++; $display("FAIL ovf_cnt n%0d got=%0h want=%0h", n, ovf_cnt_o, (n > 3) ? 3 : n); end
        end
        evt_set_i = 8'h02; ovf_clr_i = 1'b1;     // clear beats a same-cycle overflow
        tick(); evt_set_i = '0; ovf_clr_i = 1'b0;
        checks++; if (ovf_cnt_o !== 2'd0) begin errors++; $display("FAIL ovf_clr got=%0h want=0", ovf_cnt_o); end
        ack_i = 1'b1;
        tick(); ack_i = 1'b0;
        checks++; if (pending_o !== 8'h00 || valid_o !== 1'b0) begin errors++; $display("FAIL ovf_drain got=%0h/%0h want=0/0", pending_o, valid_o); end
        tick();
    endtask

    task automatic test_set_during_ack();
        evt_set_i = 8'h20;
        tick(); evt_set_i = '0;
        tick();
        checks++; if (valid_o !== 1'b1 || id_o !== 3'd5) begin errors++; $display("FAIL sda_offer got=%0h/%0h want=1/5", valid_o, id_o); end
        ack_i = 1'b1; evt_set_i = 8'h20;
        #1;
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL sda_no_ovf got=%0h want=0", ovf_o); end
        tick(); ack_i = 1'b0; evt_set_i = '0;
        checks++; if (pending_o !== 8'h20) begin errors++; $display("FAIL sda_pending got=%0h want=20", pending_o); end
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL sda_bubble got=%0h want=0", valid_o); end
        checks++; if (ovf_cnt_o !== 2'd0)  begin errors++; $display("FAIL sda_cnt got=%0h want=0", ovf_cnt_o); end
        tick();
        checks++; if (valid_o !== 1'b1 || id_o !== 3'd5) begin errors++; $display("FAIL sda_reoffer got=%0h/%0h want=1/5", valid_o, id_o); end
        ack_i = 1'b1;
        tick(); ack_i = 1'b0;
        tick();
    endtask

    task automatic test_flush();
        evt_set_i = 8'hFF;
        tick(); evt_set_i = '0;
        tick();
        checks++; if (valid_o !== 1'b1 || id_o !== 3'd0) begin errors++; $display("FAIL flush_offer got=%0h/%0h want=1/0", valid_o, id_o); end
        flush_i = 1'b1; ack_i = 1'b1;
        tick(); flush_i = 1'b0; ack_i = 1'b0;
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL flush_valid got=%0h want=0", valid_o); end
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL flush_pending got=%0h want=0", pending_o); end
        flush_i = 1'b1; evt_set_i = 8'h04;       // set discarded by flush
        tick(); flush_i = 1'b0; evt_set_i = '0;
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL flush_set got=%0h want=0", pending_o); end
        tick();
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL flush_idle got=%0h want=0", valid_o); end
    endtask

    task automatic test_async_reset();
        evt_set_i = 8'h08;
        tick(); evt_set_i = 8'h08;               // overflow so the counter is nonzero
        tick(); evt_set_i = '0;
        checks++; if (valid_o !== 1'b1 || ovf_cnt_o !== 2'd1) begin errors++; $display("FAIL ar_pre got=%0h/%0h want=1/1", valid_o, ovf_cnt_o); end
        #2 rst_i = 1'b1;                         // mid-cycle, no edge before the sample
        #1;
        checks++; if (valid_o !== 1'b0)    begin errors++; $display("FAIL ar_valid got=%0h want=0", valid_o); end
        checks++; if (id_o !== 3'd0)       begin errors++; $display("FAIL ar_id got=%0h want=0", id_o); end
        checks++; if (pending_o !== 8'h00) begin errors++; $display("FAIL ar_pending got=%0h want=0", pending_o); end
        checks++; if (ovf_o !== 1'b0)      begin errors++; $display("FAIL ar_ovf got=%0h want=0", ovf_o); end
        checks++; if (ovf_cnt_o !== 2'd0)  begin errors++; $display("FAIL ar_cnt got=%0h want=0", ovf_cnt_o); end
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_backpressure_mask();
        test_overflow();
        test_set_during_ack();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
